video_out: RTL and testbench
============================

# video_out

Display-side pixel sink placed directly downstream of the SoC's video display engine. It accepts the 24-bit RGB pixel stream over a valid/ready handshake and buffers it in a small FIFO. It generates raster timing (DE, HSYNC, VSYNC) and drives registered RGB toward the TMDS/parallel encoder. It also drives `frame_idx` back to the SoC so the producer can restart each frame in lock-step with the raster.

## Interface
Parameters:
- H_ACTIVE, 800, active pixels per line
- H_FP, 40, horizontal front porch (cycles)
- H_SYNC, 128, horizontal sync width
- H_BP, 88, horizontal back porch
- V_ACTIVE, 600, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width
- V_BP, 23, vertical back porch
- SYNC_POL, 1'b1, sync active level (1 = active-high)
- FIFO_DEPTH, 16, pixel FIFO entries (power of two, ≥2)

Ports:
- clk_i  in  1  pixel clock (one pixel per cycle)
- rstn_i  in  1  reset, asynchronous, active-low
- pixel_valid_i  in  1  producer has a pixel
- pixel_data_i  in  24  pixel {R,G,B}
- pixel_ready_o  out  1  FIFO accepts pixel this cycle
- frame_idx_o  out  1  frame parity; toggles once per frame
- de_o  out  1  data enable
- hsync_o  out  1  horizontal sync
- vsync_o  out  1  vertical sync
- rgb_o  out  24  pixel out; 0 when de_o=0
- underflow_o  out  1  sticky: active pixel needed while FIFO empty
- underflow_clr_i  in  1  clears underflow_o

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL are analogous. Counters h_cnt runs 0..H_TOTAL-1 and v_cnt runs 0..V_TOTAL-1. h_cnt wraps to 0 and v_cnt increments; v_cnt wraps after V_TOTAL-1.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for the whole line. Asserted level is SYNC_POL.
- FIFO push occurs when pixel_valid_i && pixel_ready_o. pixel_ready_o = !full && !flush && rstn_i.
- FIFO pop occurs when active && !empty. A pop and a push in the same cycle leave the count unchanged. Occupancy width is clog2(FIFO_DEPTH)+1.
- Underflow: when active && empty, no pop occurs, rgb_o = 0 with de_o = 1, and underflow_o is set. underflow_clr_i clears it. If set and clear occur in the same cycle, set wins.
- Flush occurs on the cycle where v_cnt==V_ACTIVE && h_cnt==0, which is the first blanking line.
  - Occupancy is zeroed and any push offered that cycle is discarded (ready is low).
  - frame_idx_o toggles.
  - On a frame_idx change, the producer restarts at pixel (0,0) of the next frame. This bounds misalignment from underflow or overrun to a single frame.
- Reset values: counters 0, FIFO empty, pixel_ready_o 0, de_o 0, hsync_o/vsync_o = ~SYNC_POL, rgb_o 0, frame_idx_o 0, underflow_o 0. Reset asserted mid-frame aborts immediately with no partial line. After release, the raster starts at (0,0).

## Timing
- de_o, hsync_o, vsync_o and rgb_o are registered. They reflect the counter state of the previous cycle, so all four are mutually aligned with 1-cycle latency.
- FIFO read is combinational on the head entry into the rgb_o register. A pixel popped at cycle t appears on rgb_o at t+1 with de_o=1.
- A pixel pushed at cycle t can be popped at cycle t+1 at the earliest (no fall-through).
- pixel_ready_o is combinational from registered occupancy and counters. It does not depend on pixel_valid_i.
- frame_idx_o changes one cycle after the flush cycle.
- Throughput: one pixel per cycle in and out. The FIFO fills during blanking and drains during active.

## Test plan
Test parameters: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), FIFO_DEPTH 4, SYNC_POL 1.
1. Reset release with producer idle: de_o=0 and hsync_o=vsync_o=0 on cycle 0. The first de_o pulse (rgb_o=0) appears at cycle 1, and underflow_o=1 from cycle 2 on. hsync_o is high for cycles 6–7 of each line. vsync_o is high for the 8 cycles of line 4. frame_idx_o goes 0→1 at cycle 25.
2. Producer always valid with counting data 1,2,3,…: rgb_o shows 1,2,3,4 on line 0 with de_o=1. No underflow occurs. pixel_ready_o drops when 4 entries are held.
3. Full boundary: during blanking, 4 pushes are accepted, then pixel_ready_o=0 until the first active pop. The same-cycle push+pop then keeps occupancy at 3.
4. Flush: the FIFO holds 3 entries at v_cnt=3,h_cnt=0. The next cycle shows occupancy 0, that cycle's offered push is rejected, and frame_idx_o toggles exactly once per 48 cycles.
5. Underflow clear: with underflow_o=1, assert underflow_clr_i on a non-underflow cycle → 0 next cycle. Assert it on an underflow cycle → stays 1.
6. Assert reset at h_cnt=2 of an active line with 2 entries buffered. All outputs take their reset values immediately. After release, de_o restarts at cycle 1 and the old entries are not emitted.

Source files
------------

// File: rtl/video_out.sv
// video_out: display-side pixel sink.
// Accepts a 24-bit RGB stream over valid/ready, buffers it in a small FIFO,
// generates raster timing and drives registered DE/HSYNC/VSYNC/RGB. A flush
// on the first vertical-blanking line discards leftover pixels and toggles
// frame_idx_o so the producer can restart each frame in lock-step.
//
// Ports:
//   clk_i            pixel clock (one pixel per cycle)
//   rstn_i           asynchronous active-low reset
//   pixel_valid_i    producer has a pixel
//   pixel_data_i     pixel {R,G,B}
//   pixel_ready_o    FIFO accepts a pixel this cycle
//   frame_idx_o      frame parity, toggles once per frame
//   de_o             data enable (registered)
//   hsync_o          horizontal sync (registered, SYNC_POL active level)
//   vsync_o          vertical sync (registered, SYNC_POL active level)
//   rgb_o            pixel out, zero when de_o is low or on underflow
//   underflow_o      sticky: active pixel needed while FIFO empty
//   underflow_clr_i  clears underflow_o (a same-cycle set wins)
module video_out #(
  parameter int   H_ACTIVE   = 800,
  parameter int   H_FP       = 40,
  parameter int   H_SYNC     = 128,
  parameter int   H_BP       = 88,
  parameter int   V_ACTIVE   = 600,
  parameter int   V_FP       = 1,
  parameter int   V_SYNC     = 4,
  parameter int   V_BP       = 23,
  parameter logic SYNC_POL   = 1'b1,
  parameter int   FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        pixel_valid_i,
  input  logic [23:0] pixel_data_i,
  output logic        pixel_ready_o,
  output logic        frame_idx_o,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [23:0] rgb_o,
  output logic        underflow_o,
  input  logic        underflow_clr_i
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One extra count of headroom so sync-end compares never overflow.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0]   mem_q [FIFO_DEPTH];
  logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          frame_q, frame_d, und_q, und_d;

  logic active, hs_on, vs_on, flush, full, empty, push, pop, h_wrap;

  // Raster position decode and FIFO control, all from registered state.
  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_d    = h_wrap ? '0 : h_q + 1'b1;
    v_d    = v_q;
    if (h_wrap) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;

    active = (h_q < H_ACT) && (v_q < V_ACT);
    hs_on  = (h_q >= H_SS) && (h_q < H_SE);
    vs_on  = (v_q >= V_SS) && (v_q < V_SE);
    flush  = (v_q == V_ACT) && (h_q == '0);

    full  = (cnt_q == DEPTH);
    empty = (cnt_q == '0);
    // rstn_i term keeps ready low while reset is held.
    pixel_ready_o = !full && !flush && rstn_i;
    push  = pixel_valid_i && pixel_ready_o;
    pop   = active && !empty;

    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Flush discards whatever is left; pointers realign on the write side.
    if (flush) begin
      cnt_d = '0;
      rd_d  = wr_q;
    end

    de_d    = active;
    hs_d    = hs_on ? SYNC_POL : ~SYNC_POL;
    vs_d    = vs_on ? SYNC_POL : ~SYNC_POL;
    rgb_d   = pop ? mem_q[rd_q] : '0;
    frame_d = flush ? ~frame_q : frame_q;
    und_d   = und_q;
    if (underflow_clr_i) und_d = 1'b0;
    if (active && empty) und_d = 1'b1;
  end

  // Pixel storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= pixel_data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      h_q     <= '0;
      v_q     <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      rgb_q   <= '0;
      frame_q <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      rgb_q   <= rgb_d;
      frame_q <= frame_d;
      und_q   <= und_d;
    end
  end

  assign de_o        = de_q;
  assign hsync_o     = hs_q;
  assign vsync_o     = vs_q;
  assign rgb_o       = rgb_q;
  assign frame_idx_o = frame_q;
  assign underflow_o = und_q;

endmodule

// File: tb/tb_video_out.sv
// Directed bench for video_out with a small raster: H 4/1/2/1 (8 cycles per
// line), V 3/1/1/1 (6 lines, 48 cycles per frame), FIFO depth 4. A simple
// producer restarts its counting data at 1 whenever frame_idx_o changes.
module tb_video_out;

  logic        clk;
  logic        rstn;
  logic        pixel_valid_i;
  logic [23:0] pixel_data_i;
  logic        pixel_ready_o;
  logic        frame_idx_o;
  logic        de_o;
  logic        hsync_o;
  logic        vsync_o;
  logic [23:0] rgb_o;
  logic        underflow_o;
  logic        underflow_clr_i;

  video_out #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .FIFO_DEPTH(4)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .pixel_valid_i  (pixel_valid_i),
    .pixel_data_i   (pixel_data_i),
    .pixel_ready_o  (pixel_ready_o),
    .frame_idx_o    (frame_idx_o),
    .de_o           (de_o),
    .hsync_o        (hsync_o),
    .vsync_o        (vsync_o),
    .rgb_o          (rgb_o),
    .underflow_o    (underflow_o),
    .underflow_clr_i(underflow_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks;
  int   errors;
  int   cyc;
  int   nextval;
  logic started;
  logic prod_en;
  logic frame_seen;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Producer idle windows (cycle numbers counted from reset release).
  function automatic logic paused(input int c);
    return (c >= 68 && c <= 71) || (c >= 100 && c <= 120) || (c >= 145);
  endfunction

  // One clock: inputs for the new cycle are driven 1 time unit after the edge.
  task automatic step();
    logic acc;
    acc = pixel_valid_i && pixel_ready_o;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) nextval++;
    if (prod_en && (frame_idx_o !== frame_seen)) begin
      nextval = 1;
      started = 1'b1;
    end
    frame_seen      = frame_idx_o;
    pixel_valid_i   = started && !paused(cyc);
    pixel_data_i    = 24'(nextval);
    underflow_clr_i = (cyc == 44) || (cyc == 107);
  endtask

  initial begin
    int n, h, v;
    checks = 0; errors = 0; cyc = 0; nextval = 1;
    started = 1'b0; prod_en = 1'b1; frame_seen = 1'b0;
    rstn = 1'b0; pixel_valid_i = 1'b0; pixel_data_i = '0; underflow_clr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_ready", pixel_ready_o, 1'b0);
    chk1("rst_de", de_o, 1'b0);
    chk1("rst_hsync", hsync_o, 1'b0);
    chk1("rst_vsync", vsync_o, 1'b0);
    chk24("rst_rgb", rgb_o, 24'd0);
    chk1("rst_frame", frame_idx_o, 1'b0);
    chk1("rst_underflow", underflow_o, 1'b0);

    // Release: cycle 0 is raster position (0,0).
    rstn = 1'b1;
    #1;
    chk1("c0_de", de_o, 1'b0);
    chk1("c0_hsync", hsync_o, 1'b0);
    chk1("c0_vsync", vsync_o, 1'b0);
    chk1("c0_ready", pixel_ready_o, 1'b1);

    // Frame 1, producer idle until the first frame_idx change at cycle 25.
    for (int k = 1; k <= 44; k++) begin
      step();
      n = k - 1; h = n % 8; v = (n / 8) % 6;
      chk1("t1_de", de_o, (h < 4) && (v < 3));
      chk1("t1_hsync", hsync_o, (h >= 5) && (h < 7));
      chk1("t1_vsync", vsync_o, v == 4);
      chk24("t1_rgb", rgb_o, 24'd0);
      chk1("t1_frame", frame_idx_o, k >= 25);
      chk1("t1_ready", pixel_ready_o, (k <= 23) || (k >= 25 && k <= 28));
      if (k >= 2) chk1("t1_underflow", underflow_o, 1'b1);
    end

    // Frames 2..4: streaming, full boundary, flush, underflow clear.
    while (cyc < 146) begin
      step();
      if (cyc <= 107) chk1("und_clear", underflow_o, 1'b0);
      else            chk1("und_set", underflow_o, 1'b1);
      if (cyc >= 49 && cyc <= 52) begin
        chk1("l0_de", de_o, 1'b1); chk24("l0_rgb", rgb_o, 24'(cyc - 48));
      end
      if (cyc >= 57 && cyc <= 60) chk24("l1_rgb", rgb_o, 24'(cyc - 52));
      if (cyc >= 65 && cyc <= 68) chk24("l2_rgb", rgb_o, 24'(cyc - 56));
      if (cyc >= 97 && cyc <= 100) chk24("f3_rgb", rgb_o, 24'(cyc - 96));
      if (cyc >= 105 && cyc <= 107) chk24("f3_l1_rgb", rgb_o, 24'(cyc - 100));
      if (cyc == 53) begin
        chk1("blank_de", de_o, 1'b0); chk24("blank_rgb", rgb_o, 24'd0);
      end
      if (cyc == 108) begin
        chk1("und_de", de_o, 1'b1); chk24("und_rgb", rgb_o, 24'd0);
      end
      if (cyc == 48) chk1("full_ready", pixel_ready_o, 1'b0);
      if (cyc == 49) chk1("pushpop_ready", pixel_ready_o, 1'b1);
      if (cyc == 52) chk1("occ3_ready", pixel_ready_o, 1'b1);
      if (cyc == 53) chk1("refull_ready", pixel_ready_o, 1'b0);
      if (cyc == 72) begin
        chk1("flush_ready", pixel_ready_o, 1'b0);
        chk1("flush_frame", frame_idx_o, 1'b1);
      end
      if (cyc == 73) chk1("post_flush_frame", frame_idx_o, 1'b0);
      if (cyc == 74) chk1("post_flush_ready", pixel_ready_o, 1'b1);
      if (cyc == 76) chk1("f3_ready3", pixel_ready_o, 1'b1);
      if (cyc == 77) chk1("f3_full", pixel_ready_o, 1'b0);
      if (cyc == 120) chk1("f3_frame", frame_idx_o, 1'b0);
      if (cyc == 121) chk1("f4_frame", frame_idx_o, 1'b1);
      if (cyc == 145) chk24("f4_rgb0", rgb_o, 24'd1);
      if (cyc == 146) chk24("f4_rgb1", rgb_o, 24'd2);
    end

    // Mid-line reset with two pixels still buffered.
    rstn = 1'b0;
    #1;
    chk1("mid_rst_de", de_o, 1'b0);
    chk1("mid_rst_hsync", hsync_o, 1'b0);
    chk1("mid_rst_vsync", vsync_o, 1'b0);
    chk24("mid_rst_rgb", rgb_o, 24'd0);
    chk1("mid_rst_ready", pixel_ready_o, 1'b0);
    chk1("mid_rst_frame", frame_idx_o, 1'b0);
    chk1("mid_rst_underflow", underflow_o, 1'b0);
    prod_en = 1'b0; started = 1'b0; pixel_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc = 0;
    frame_seen = 1'b0;
    #1;
    chk1("rel_c0_de", de_o, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk1("rel_de", de_o, 1'b1);
      chk24("rel_rgb", rgb_o, 24'd0);
      if (k >= 2) chk1("rel_underflow", underflow_o, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
